// File: rtl/example_mul_share_arb.sv
// Shared 7x14 signed multiplier with round-robin arbitration among
// NUM_REQ requesters, feeding a two-stage valid/ready pipeline.
module example_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NUM_REQ-1:0]    req_vld,
  output logic [NUM_REQ-1:0]    req_rdy,
  input  logic [NUM_REQ*7-1:0]  req_a,
  input  logic [NUM_REQ*14-1:0] req_b,
  output logic                  res_vld,
  input  logic                  res_rdy,
  output logic [ID_W-1:0]       res_id,
  output logic [20:0]           res_p,
  output logic                  busy,
  output logic [15:0]           op_cnt
);

  // Pipeline stage 1: operands and owner
  logic                   r_s1_vld;
  logic [6:0]             r_s1_a;
  logic signed [13:0]     r_s1_b;
  logic [ID_W-1:0]        r_s1_id;
  // Pipeline stage 2: product and owner
  logic                   r_s2_vld;
  logic signed [20:0]     r_s2_p;
  logic [ID_W-1:0]        r_s2_id;
  // Arbitration pointer, handshake counter, reset-release delay
  logic [ID_W-1:0]        r_last;
  logic [15:0]            r_op_cnt;
  logic                   r_rst_d;

  logic                   w_adv1;
  logic                   w_adv2;
  logic                   w_gnt_en;
  logic [NUM_REQ-1:0]     w_gnt;
  logic                   w_gnt_any;
  logic [ID_W-1:0]        w_gnt_id;
  logic [6:0]             w_sel_a;
  logic [13:0]            w_sel_b;
  logic signed [21:0]     w_prod;
  logic [6:0]             w_a [NUM_REQ];
  logic [13:0]            w_b [NUM_REQ];

  // Unpack the flat operand buses into per-requester lanes
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a[gi] = req_a[7*gi +: 7];
    assign w_b[gi] = req_b[14*gi +: 14];
  end

  assign w_adv2 = ~r_s2_vld | res_rdy;
  assign w_adv1 = ~r_s1_vld | w_adv2;
  // No grants while in reset or in the first cycle after it
  assign w_gnt_en = w_adv1 & ~ap_rst & ~r_rst_d;

  // Round-robin search starting just after the last granted requester;
  // iterating from the farthest candidate lets the nearest one win
  always_comb begin
    int idx;
    w_gnt     = '0;
    w_gnt_any = 1'b0;
    w_gnt_id  = r_last;
    idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(r_last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (w_gnt_en && req_vld[idx]) begin
        w_gnt      = '0;
        w_gnt[idx] = 1'b1;
        w_gnt_any  = 1'b1;
        w_gnt_id   = ID_W'(idx);
      end
    end
  end

  // AND-OR operand mux driven by the one-hot grant
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_a = w_sel_a | w_a[i];
        w_sel_b = w_sel_b | w_b[i];
      end
    end
  end

  // a is unsigned: zero-extend before the signed multiply; result fits 21 bits
  assign w_prod = $signed({1'b0, r_s1_a}) * r_s1_b;

  // Control state: valids, pointer, counter
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_last   <= ID_W'(NUM_REQ - 1);
      r_op_cnt <= 16'd0;
    end else begin
      if (w_adv2) r_s2_vld <= r_s1_vld;
      if (w_adv1) r_s1_vld <= w_gnt_any;
      if (w_gnt_any) r_last <= w_gnt_id;
      if (r_s2_vld && res_rdy) r_op_cnt <= r_op_cnt + 16'd1;
    end
  end

  // Remember reset for one cycle so grants stay off right after release
  always_ff @(posedge ap_clk) begin
    r_rst_d <= ap_rst;
  end

  // Datapath registers; qualified by the valids so they need no reset
  always_ff @(posedge ap_clk) begin
    if (w_adv2) begin
      r_s2_p  <= w_prod[20:0];
      r_s2_id <= r_s1_id;
    end
    if (w_adv1 && w_gnt_any) begin
      r_s1_a  <= w_sel_a;
      r_s1_b  <= w_sel_b;
      r_s1_id <= w_gnt_id;
    end
  end

  assign req_rdy = w_gnt;
  assign res_vld = r_s2_vld;
  assign res_id  = r_s2_id;
  assign res_p   = r_s2_p;
  assign busy    = r_s1_vld | r_s2_vld;
  assign op_cnt  = r_op_cnt;

endmodule
